// File: rtl/dmem_slave.sv
// Data-memory responder with valid/ready request and response channels and programmable wait states.
// Optional access-error detection is enabled by defining DMEM_SLAVE_ERR_EN.
module dmem_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic [3:0]      cnt_next;
  logic            accept;
  logic            do_access;
  logic            ready_q;
  logic            req_err;
  logic            lat_write;
  logic [AW-1:0]   lat_idx;
  logic [31:0]     lat_wdata;
  logic [3:0]      lat_be;
  logic            lat_err;
  logic [31:0]     mem [DEPTH_WORDS];

`ifdef DMEM_SLAVE_ERR_EN
  function automatic logic addr_err(input logic [31:0] a);
    addr_err = (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
  endfunction

  assign req_err = addr_err(req_addr);
`else
  // Low and high address bits are don't-care here: addresses wrap.
  logic unused_addr;
  assign unused_addr = ^{req_addr[31:AW+2], req_addr[1:0]};
  assign req_err     = 1'b0;
`endif

  // Ready is held low for as long as reset is asserted, then follows the registered IDLE flag.
  assign req_ready = ready_q & ~reset;

  // Next-state logic; the access fires on the edge after the counter has drained to zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    do_access  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept     = 1'b1;
          cnt_next   = WAIT_INIT;
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          do_access  = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next   = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control state, request latches and registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready_q   <= 1'b1;
      lat_write <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      lat_err   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      ready_q <= (state_next == IDLE);
      if (accept) begin
        lat_write <= req_write;
        lat_idx   <= req_addr[AW+1:2];
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        lat_err   <= req_err;
      end
      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= lat_err;
        rsp_rdata <= (lat_write || lat_err) ? 32'd0 : mem[lat_idx];
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // Byte-enabled store commit; memory is never cleared and a reset edge suppresses the commit.
  always_ff @(posedge clock) begin
    if (!reset && do_access && lat_write && !lat_err) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
